// File: rtl/regfile_pkg.sv
// Shared definitions for the banked register file: bank-select encoding
// and the default geometry.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 32;

    typedef enum logic {
        BANK_INT = 1'b0,
        BANK_FP  = 1'b1
    } bank_e;

endpackage

// File: rtl/regfile_bank.sv
// One register bank: storage, busy (pending) bits, a write port, a
// reservation port and two registered read ports.
//
// Each read port forwards the state the addressed register holds after
// this edge. A same-edge write supplies the data and clears busy. A
// same-edge reservation sets busy and wins over the write's clear.
module regfile_bank
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_en,
    input  logic [AW-1:0]     i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rsv_en,
    input  logic [AW-1:0]     i_rsv_addr,
    input  logic [AW-1:0]     i_rd1_addr,
    input  logic [AW-1:0]     i_rd2_addr,
    output logic [DATA_W-1:0] o_rd1_data,
    output logic              o_rd1_busy,
    output logic [DATA_W-1:0] o_rd2_data,
    output logic              o_rd2_busy
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_busy;
    logic [DATA_W:0]   w_rd1_next;
    logic [DATA_W:0]   w_rd2_next;

    // Post-edge view of one register: {busy, data}, with same-edge forwarding.
    function automatic logic [DATA_W:0] f_lookup(input logic [AW-1:0] addr);
        logic              busy;
        logic [DATA_W-1:0] data;
        data = r_mem[addr];
        busy = r_busy[addr];
        if (i_wr_en && (i_wr_addr == addr)) begin
            data = i_wr_data;
            busy = 1'b0;
        end else begin
            data = data;
        end
        if (i_rsv_en && (i_rsv_addr == addr)) begin
            busy = 1'b1;
        end else begin
            busy = busy;
        end
        return {busy, data};
    endfunction

    // Next read values for both ports.
    always_comb begin
        w_rd1_next = f_lookup(i_rd1_addr);
        w_rd2_next = f_lookup(i_rd2_addr);
    end

    // Storage and busy bits; the reservation assignment comes last so it wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_busy <= '0;
        end else begin
            if (i_wr_en) begin
                r_mem[i_wr_addr]  <= i_wr_data;
                r_busy[i_wr_addr] <= 1'b0;
            end
            if (i_rsv_en) begin
                r_busy[i_rsv_addr] <= 1'b1;
            end
        end
    end

    // Registered read outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_rd1_data <= '0;
            o_rd1_busy <= 1'b0;
            o_rd2_data <= '0;
            o_rd2_busy <= 1'b0;
        end else begin
            o_rd1_data <= w_rd1_next[DATA_W-1:0];
            o_rd1_busy <= w_rd1_next[DATA_W];
            o_rd2_data <= w_rd2_next[DATA_W-1:0];
            o_rd2_busy <= w_rd2_next[DATA_W];
        end
    end

endmodule

// File: rtl/banked_reg_file.sv
// Integer + float register file with per-register pending bits.
// The top steers writes and reservations to the selected bank, keeps
// integer r0 at zero when INT_ZERO is set, and picks each read port's
// bank using the select captured at the sampling edge.
module banked_reg_file
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int INT_ZERO = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     rd1_addr,
    input  logic [AW-1:0]     rd2_addr,
    input  logic              rd1_fp,
    input  logic              rd2_fp,
    input  logic              wr_en,
    input  logic              wr_fp,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rsv_en,
    input  logic              rsv_fp,
    input  logic [AW-1:0]     rsv_addr,
    output logic [DATA_W-1:0] rd1_data,
    output logic [DATA_W-1:0] rd2_data,
    output logic              rd1_busy,
    output logic              rd2_busy
);

    logic              w_int_wr_en;
    logic              w_fp_wr_en;
    logic              w_int_rsv_en;
    logic              w_fp_rsv_en;
    logic [DATA_W-1:0] w_int_rd1_data;
    logic [DATA_W-1:0] w_int_rd2_data;
    logic [DATA_W-1:0] w_fp_rd1_data;
    logic [DATA_W-1:0] w_fp_rd2_data;
    logic              w_int_rd1_busy;
    logic              w_int_rd2_busy;
    logic              w_fp_rd1_busy;
    logic              w_fp_rd2_busy;
    bank_e             r_rd1_bank;
    bank_e             r_rd2_bank;

    // Integer r0 is read-only zero: writes/reservations to it are dropped,
    // so after reset it can only ever hold 0 with busy 0.
    always_comb begin
        w_int_wr_en  = wr_en  && (bank_e'(wr_fp)  == BANK_INT) &&
                       !((INT_ZERO != 0) && (wr_addr  == '0));
        w_int_rsv_en = rsv_en && (bank_e'(rsv_fp) == BANK_INT) &&
                       !((INT_ZERO != 0) && (rsv_addr == '0));
        w_fp_wr_en   = wr_en  && (bank_e'(wr_fp)  == BANK_FP);
        w_fp_rsv_en  = rsv_en && (bank_e'(rsv_fp) == BANK_FP);
    end

    regfile_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_int_bank (
        .clk        (clk),
        .rst        (rst),
        .i_wr_en    (w_int_wr_en),
        .i_wr_addr  (wr_addr),
        .i_wr_data  (wr_data),
        .i_rsv_en   (w_int_rsv_en),
        .i_rsv_addr (rsv_addr),
        .i_rd1_addr (rd1_addr),
        .i_rd2_addr (rd2_addr),
        .o_rd1_data (w_int_rd1_data),
        .o_rd1_busy (w_int_rd1_busy),
        .o_rd2_data (w_int_rd2_data),
        .o_rd2_busy (w_int_rd2_busy)
    );

    regfile_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fp_bank (
        .clk        (clk),
        .rst        (rst),
        .i_wr_en    (w_fp_wr_en),
        .i_wr_addr  (wr_addr),
        .i_wr_data  (wr_data),
        .i_rsv_en   (w_fp_rsv_en),
        .i_rsv_addr (rsv_addr),
        .i_rd1_addr (rd1_addr),
        .i_rd2_addr (rd2_addr),
        .o_rd1_data (w_fp_rd1_data),
        .o_rd1_busy (w_fp_rd1_busy),
        .o_rd2_data (w_fp_rd2_data),
        .o_rd2_busy (w_fp_rd2_busy)
    );

    // Capture each port's bank select alongside the banks' registered reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd1_bank <= BANK_INT;
            r_rd2_bank <= BANK_INT;
        end else begin
            r_rd1_bank <= bank_e'(rd1_fp);
            r_rd2_bank <= bank_e'(rd2_fp);
        end
    end

    // Select between two registered bank outputs; both are 0 after reset.
    always_comb begin
        if (r_rd1_bank == BANK_FP) begin
            rd1_data = w_fp_rd1_data;
            rd1_busy = w_fp_rd1_busy;
        end else begin
            rd1_data = w_int_rd1_data;
            rd1_busy = w_int_rd1_busy;
        end
        if (r_rd2_bank == BANK_FP) begin
            rd2_data = w_fp_rd2_data;
            rd2_busy = w_fp_rd2_busy;
        end else begin
            rd2_data = w_int_rd2_data;
            rd2_busy = w_int_rd2_busy;
        end
    end

endmodule
